nco_sweep_ctrl: RTL and testbench

Sequencer that drives the phase_inc input of the 8-bit nco. It steps the NCO frequency from a start increment to a stop increment in fixed steps, holding each value for a programmable dwell. Supports a one-shot sweep or a continuous triangle sweep. Uses a start/busy/done handshake and abort, and holds the NCO in reset while idle.

---
 rtl/nco_ctrl_pkg.sv | 21 ++
 rtl/nco_step_calc.sv | 55 +++++
 rtl/nco_sweep_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nco_ctrl_pkg
// Shared types and constants for the NCO sweep controller.
//   state_e     : sequencer states (IDLE, RUN)
//   MODE_*      : sweep mode encoding (single sweep / continuous triangle)
//   DIR_*       : sweep direction encoding
// -----------------------------------------------------------------------------
package nco_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_TRI    = 1'b1;

    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;

endpackage

// File: rtl/nco_step_calc.sv
// -----------------------------------------------------------------------------
// nco_step_calc
// Combinational next-increment calculator. Adds or subtracts the step at
// PHASE_W+1 bits so a carry/borrow is visible, then clamps to the endpoint.
// Ports:
//   i_cur         current phase increment
//   i_step        unsigned step magnitude
//   i_stop        endpoint of the current leg
//   i_dir         DIR_UP / DIR_DOWN
//   o_next        next phase increment (never wraps)
//   o_at_endpoint high when o_next equals the endpoint after clamping
// -----------------------------------------------------------------------------
module nco_step_calc
    import nco_ctrl_pkg::*;
#(
    parameter int PHASE_W = 8
) (
    input  logic [PHASE_W-1:0] i_cur,
    input  logic [PHASE_W-1:0] i_step,
    input  logic [PHASE_W-1:0] i_stop,
    input  logic               i_dir,
    output logic [PHASE_W-1:0] o_next,
    output logic               o_at_endpoint
);

    logic [PHASE_W:0] w_sum;
    logic [PHASE_W:0] w_diff;

    assign w_sum  = {1'b0, i_cur} + {1'b0, i_step};
    assign w_diff = {1'b0, i_cur} - {1'b0, i_step};

    // Step toward the endpoint; overshoot or carry/borrow clamps to the endpoint.
    always_comb begin
        o_next        = i_cur;
        o_at_endpoint = 1'b0;
        if (i_dir == DIR_UP) begin
            if (w_sum[PHASE_W] || (w_sum[PHASE_W-1:0] >= i_stop)) begin
                o_next        = i_stop;
                o_at_endpoint = 1'b1;
            end else begin
                o_next        = w_sum[PHASE_W-1:0];
                o_at_endpoint = 1'b0;
            end
        end else begin
            if (w_diff[PHASE_W] || (w_diff[PHASE_W-1:0] <= i_stop)) begin
                o_next        = i_stop;
                o_at_endpoint = 1'b1;
            end else begin
                o_next        = w_diff[PHASE_W-1:0];
                o_at_endpoint = 1'b0;
            end
        end
    end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// nco_sweep_ctrl
// Drives the phase_inc input of the NCO, stepping from a start to a stop
// increment with a fixed dwell per value. Single sweep or continuous triangle.
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   start, abort          sweep request (IDLE only) / terminate sweep
//   cfg_start_inc/stop/step/dwell/mode   sweep configuration, latched on start
//   phase_inc             registered increment to the NCO
//   nco_rst               registered NCO reset, high while idle
//   busy                  high from first load until termination
//   step_pulse            one-cycle pulse on each phase_inc update
//   done                  one-cycle pulse at the end of a single sweep
// -----------------------------------------------------------------------------
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int PHASE_W = 8,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [PHASE_W-1:0] cfg_start_inc,
    input  logic [PHASE_W-1:0] cfg_stop_inc,
    input  logic [PHASE_W-1:0] cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_mode,
    output logic [PHASE_W-1:0] phase_inc,
    output logic               nco_rst,
    output logic               busy,
    output logic               step_pulse,
    output logic               done
);

    state_e r_state, w_state_nxt;

    // Shadow configuration. r_origin/r_target swap at each triangle turn.
    logic [PHASE_W-1:0] r_origin, w_origin_nxt;
    logic [PHASE_W-1:0] r_target, w_target_nxt;
    logic [PHASE_W-1:0] r_step, w_step_nxt;
    logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
    logic               r_mode, w_mode_nxt;
    logic               r_dir, w_dir_nxt;

    logic [PHASE_W-1:0] r_phase_inc, w_phase_inc_nxt;
    logic               r_nco_rst, w_nco_rst_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_step_pulse, w_step_pulse_nxt;
    logic               r_done, w_done_nxt;
    logic [DWELL_W-1:0] r_dwell_cnt, w_dwell_cnt_nxt;
    logic               r_at_end, w_at_end_nxt;
    // First RUN cycle: the latched start value has not been loaded yet.
    logic               r_first, w_first_nxt;

    logic               w_launch;
    logic               w_expire;
    logic               w_degenerate;
    logic [PHASE_W-1:0] w_calc_stop;
    logic               w_calc_dir;
    logic [PHASE_W-1:0] w_calc_next;
    logic               w_calc_at_end;

    assign w_launch     = start && !abort;
    assign w_expire     = (r_dwell_cnt == {DWELL_W{1'b0}}) && !r_first;
    assign w_degenerate = (r_step == {PHASE_W{1'b0}}) || (r_origin == r_target);

    // At an endpoint the next value is computed against the swapped leg.
    assign w_calc_stop  = r_at_end ? r_origin : r_target;
    assign w_calc_dir   = r_at_end ? ~r_dir : r_dir;

    nco_step_calc #(
        .PHASE_W (PHASE_W)
    ) u_step_calc (
        .i_cur         (r_phase_inc),
        .i_step        (r_step),
        .i_stop        (w_calc_stop),
        .i_dir         (w_calc_dir),
        .o_next        (w_calc_next),
        .o_at_endpoint (w_calc_at_end)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort has priority over dwell expiry.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_launch) w_state_nxt = RUN;
                else          w_state_nxt = IDLE;
            end
            RUN: begin
                if (abort)                                        w_state_nxt = IDLE;
                else if (w_expire && r_at_end && (r_mode == MODE_SINGLE)) w_state_nxt = IDLE;
                else                                              w_state_nxt = RUN;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        w_origin_nxt     = r_origin;
        w_target_nxt     = r_target;
        w_step_nxt       = r_step;
        w_dwell_nxt      = r_dwell;
        w_mode_nxt       = r_mode;
        w_dir_nxt        = r_dir;
        w_phase_inc_nxt  = r_phase_inc;
        w_nco_rst_nxt    = r_nco_rst;
        w_busy_nxt       = r_busy;
        w_step_pulse_nxt = 1'b0;
        w_done_nxt       = 1'b0;
        w_dwell_cnt_nxt  = r_dwell_cnt;
        w_at_end_nxt     = r_at_end;
        w_first_nxt      = 1'b0;
        case (r_state)
            IDLE: begin
                w_nco_rst_nxt = 1'b1;
                w_busy_nxt    = 1'b0;
                if (w_launch) begin
                    w_origin_nxt = cfg_start_inc;
                    w_target_nxt = cfg_stop_inc;
                    w_step_nxt   = cfg_step;
                    w_dwell_nxt  = (cfg_dwell == {DWELL_W{1'b0}}) ?
                                   {{(DWELL_W-1){1'b0}}, 1'b1} : cfg_dwell;
                    w_mode_nxt   = cfg_mode;
                    w_dir_nxt    = (cfg_start_inc > cfg_stop_inc) ? DIR_DOWN : DIR_UP;
                    w_first_nxt  = 1'b1;
                end else begin
                    w_first_nxt  = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    w_nco_rst_nxt = 1'b1;
                    w_busy_nxt    = 1'b0;
                end else if (r_first) begin
                    w_phase_inc_nxt  = r_origin;
                    w_step_pulse_nxt = 1'b1;
                    w_nco_rst_nxt    = 1'b0;
                    w_busy_nxt       = 1'b1;
                    w_dwell_cnt_nxt  = r_dwell - {{(DWELL_W-1){1'b0}}, 1'b1};
                    w_at_end_nxt     = w_degenerate;
                end else if (!w_expire) begin
                    w_dwell_cnt_nxt  = r_dwell_cnt - {{(DWELL_W-1){1'b0}}, 1'b1};
                end else if (r_at_end && (r_mode == MODE_SINGLE)) begin
                    w_nco_rst_nxt    = 1'b1;
                    w_busy_nxt       = 1'b0;
                    w_done_nxt       = 1'b1;
                end else if (r_at_end && w_degenerate) begin
                    // Triangle with a single distinct value: just keep holding it.
                    w_dwell_cnt_nxt  = r_dwell - {{(DWELL_W-1){1'b0}}, 1'b1};
                end else begin
                    if (r_at_end) begin
                        w_origin_nxt = r_target;
                        w_target_nxt = r_origin;
                        w_dir_nxt    = ~r_dir;
                    end else begin
                        w_dir_nxt    = r_dir;
                    end
                    w_phase_inc_nxt  = w_calc_next;
                    w_at_end_nxt     = w_calc_at_end;
                    w_step_pulse_nxt = 1'b1;
                    w_dwell_cnt_nxt  = r_dwell - {{(DWELL_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_nco_rst_nxt = 1'b1;
                w_busy_nxt    = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_origin     <= {PHASE_W{1'b0}};
            r_target     <= {PHASE_W{1'b0}};
            r_step       <= {PHASE_W{1'b0}};
            r_dwell      <= {DWELL_W{1'b0}};
            r_mode       <= MODE_SINGLE;
            r_dir        <= DIR_UP;
            r_phase_inc  <= {PHASE_W{1'b0}};
            r_nco_rst    <= 1'b1;
            r_busy       <= 1'b0;
            r_step_pulse <= 1'b0;
            r_done       <= 1'b0;
            r_dwell_cnt  <= {DWELL_W{1'b0}};
            r_at_end     <= 1'b0;
            r_first      <= 1'b0;
        end else begin
            r_origin     <= w_origin_nxt;
            r_target     <= w_target_nxt;
            r_step       <= w_step_nxt;
            r_dwell      <= w_dwell_nxt;
            r_mode       <= w_mode_nxt;
            r_dir        <= w_dir_nxt;
            r_phase_inc  <= w_phase_inc_nxt;
            r_nco_rst    <= w_nco_rst_nxt;
            r_busy       <= w_busy_nxt;
            r_step_pulse <= w_step_pulse_nxt;
            r_done       <= w_done_nxt;
            r_dwell_cnt  <= w_dwell_cnt_nxt;
            r_at_end     <= w_at_end_nxt;
            r_first      <= w_first_nxt;
        end
    end

    assign phase_inc  = r_phase_inc;
    assign nco_rst    = r_nco_rst;
    assign busy       = r_busy;
    assign step_pulse = r_step_pulse;
    assign done       = r_done;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nco_sweep_ctrl
// Table-driven single-sweep vectors plus hand-written triangle, abort and
// reset sequences for nco_sweep_ctrl.
// -----------------------------------------------------------------------------
module tb_nco_sweep_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  cfg_start_inc;
    logic [7:0]  cfg_stop_inc;
    logic [7:0]  cfg_step;
    logic [15:0] cfg_dwell;
    logic        cfg_mode;
    logic [7:0]  phase_inc;
    logic        nco_rst;
    logic        busy;
    logic        step_pulse;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    nco_sweep_ctrl #(.PHASE_W(8), .DWELL_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .cfg_start_inc (cfg_start_inc),
        .cfg_stop_inc  (cfg_stop_inc),
        .cfg_step      (cfg_step),
        .cfg_dwell     (cfg_dwell),
        .cfg_mode      (cfg_mode),
        .phase_inc     (phase_inc),
        .nco_rst       (nco_rst),
        .busy          (busy),
        .step_pulse    (step_pulse),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  s_inc;
        logic [7:0]  p_inc;
        logic [7:0]  step;
        logic [15:0] dwell;
        int          n;      // distinct values
        int          d;      // effective dwell
        int          lat;    // start edge to done edge
        logic [39:0] exp;    // expected values, byte 0 first
    } vec_t;

    vec_t vecs [8];
    int   nvec = 0;

    task automatic add_vec(input logic [7:0] s, input logic [7:0] p, input logic [7:0] st,
                           input logic [15:0] dw, input int n, input int d, input int lat,
                           input logic [39:0] e);
        vecs[nvec].s_inc = s;
        vecs[nvec].p_inc = p;
        vecs[nvec].step  = st;
        vecs[nvec].dwell = dw;
        vecs[nvec].n     = n;
        vecs[nvec].d     = d;
        vecs[nvec].lat   = lat;
        vecs[nvec].exp   = e;
        nvec++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] s, input logic [7:0] p, input logic [7:0] st,
                           input logic [15:0] dw, input logic m);
        cfg_start_inc = s;
        cfg_stop_inc  = p;
        cfg_step      = st;
        cfg_dwell     = dw;
        cfg_mode      = m;
    endtask

    logic [7:0] exp_tri [4];
    logic [7:0] exp_v;
    int         pc;
    bit         fin;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(8'h00, 8'h00, 8'h00, 16'd0, 1'b0);

        add_vec(8'h10, 8'h20, 8'h04, 16'd3, 5, 3, 16, {8'h20, 8'h1C, 8'h18, 8'h14, 8'h10});
        add_vec(8'h10, 8'h1E, 8'h04, 16'd1, 5, 1, 6,  {8'h1E, 8'h1C, 8'h18, 8'h14, 8'h10});
        add_vec(8'hF0, 8'hFF, 8'h20, 16'd1, 2, 1, 3,  {8'h00, 8'h00, 8'h00, 8'hFF, 8'hF0});
        add_vec(8'hF0, 8'h08, 8'h40, 16'd2, 5, 2, 11, {8'h08, 8'h30, 8'h70, 8'hB0, 8'hF0});
        add_vec(8'h33, 8'h99, 8'h00, 16'd0, 1, 1, 2,  {8'h00, 8'h00, 8'h00, 8'h00, 8'h33});
        add_vec(8'h55, 8'h55, 8'h03, 16'd2, 1, 2, 3,  {8'h00, 8'h00, 8'h00, 8'h00, 8'h55});
        add_vec(8'h20, 8'h05, 8'h30, 16'd1, 2, 1, 3,  {8'h00, 8'h00, 8'h00, 8'h05, 8'h20});

        #12;
        chk("rst_phase_inc", {24'd0, phase_inc}, 32'h00);
        chk("rst_flags", {27'd0, nco_rst, busy, step_pulse, done, 1'b0}, {27'd0, 5'b10000});
        reset = 1'b0;
        tick();
        chk("idle_flags", {28'd0, nco_rst, busy, step_pulse, done}, {28'd0, 4'b1000});

        // Table-driven single sweeps; vector 0 also gets a start pulse and cfg churn mid-sweep.
        for (int v = 0; v < nvec; v++) begin
            set_cfg(vecs[v].s_inc, vecs[v].p_inc, vecs[v].step, vecs[v].dwell, 1'b0);
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("load_lag", {30'd0, busy, step_pulse}, 32'd0);
            pc  = 0;
            fin = 1'b0;
            for (int e = 1; e <= 200 && !fin; e++) begin
                tick();
                if (step_pulse) begin
                    if (pc < vecs[v].n) begin
                        exp_v = vecs[v].exp[8*pc +: 8];
                        chk($sformatf("v%0d_value%0d", v, pc), {24'd0, phase_inc}, {24'd0, exp_v});
                        chk($sformatf("v%0d_time%0d", v, pc), e, 1 + pc * vecs[v].d);
                    end else begin
                        chk($sformatf("v%0d_extra_pulse", v), pc, vecs[v].n - 1);
                    end
                    pc++;
                end
                if (e < vecs[v].lat) begin
                    chk($sformatf("v%0d_run_flags", v), {29'd0, busy, nco_rst, done}, {29'd0, 3'b100});
                end else begin
                    chk($sformatf("v%0d_done_edge", v), {28'd0, busy, nco_rst, done, step_pulse},
                        {28'd0, 4'b0110});
                    fin = 1'b1;
                end
                if (v == 0 && e == 4) begin
                    start = 1'b1;
                    set_cfg(8'hAA, 8'h00, 8'h01, 16'd7, 1'b1);
                end
                if (v == 0 && e == 5) start = 1'b0;
            end
            if (!fin) chk($sformatf("v%0d_timeout", v), 32'd0, 32'd1);
            chk($sformatf("v%0d_pulse_count", v), pc, vecs[v].n);
            tick();
            exp_v = vecs[v].exp[8*(vecs[v].n-1) +: 8];
            chk($sformatf("v%0d_hold", v), {22'd0, phase_inc, busy, done}, {22'd0, exp_v, 2'b00});
        end

        // Triangle sweep 04..0C, step 4, dwell 1.
        exp_tri[0] = 8'h04; exp_tri[1] = 8'h08; exp_tri[2] = 8'h0C; exp_tri[3] = 8'h08;
        set_cfg(8'h04, 8'h0C, 8'h04, 16'd1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk($sformatf("tri_value%0d", e), {24'd0, phase_inc}, {24'd0, exp_tri[(e-1) % 4]});
            chk($sformatf("tri_flags%0d", e), {28'd0, busy, nco_rst, step_pulse, done},
                {28'd0, 4'b1010});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("tri_abort", {20'd0, phase_inc, busy, nco_rst, step_pulse, done},
            {20'd0, 8'h08, 4'b0100});

        // Degenerate triangle holds its only value without further updates.
        set_cfg(8'h40, 8'h40, 8'h04, 16'd1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("deg_tri_load", {22'd0, phase_inc, busy, step_pulse}, {22'd0, 8'h40, 2'b11});
        for (int e = 0; e < 5; e++) begin
            tick();
            chk("deg_tri_hold", {21'd0, phase_inc, busy, step_pulse, done},
                {21'd0, 8'h40, 3'b100});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("deg_tri_abort", {30'd0, busy, nco_rst}, {30'd0, 2'b01});

        // Abort wins over a simultaneous dwell expiry.
        set_cfg(8'h10, 8'h20, 8'h04, 16'd2, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_vs_expiry", {20'd0, phase_inc, busy, nco_rst, step_pulse, done},
            {20'd0, 8'h10, 4'b0100});

        // start together with abort in IDLE is ignored.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        tick();
        chk("start_abort_idle", {28'd0, busy, nco_rst, step_pulse, done}, {28'd0, 4'b0100});

        // Reset asserted mid-sweep takes effect before the next clock edge.
        set_cfg(8'h10, 8'h20, 8'h04, 16'd3, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e < 5; e++) tick();
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_reset", {19'd0, phase_inc, nco_rst, busy, step_pulse, done, 1'b0},
            {19'd0, 8'h00, 5'b10000});
        #2;
        reset = 1'b0;
        tick();
        chk("post_reset_idle", {28'd0, busy, nco_rst, step_pulse, done}, {28'd0, 4'b0100});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
